and_gate_stim_checker: RTL

//   Self-checking stimulus/monitor stage wrapped around the 2-input AND gate.

---
 rtl/and_gate_stim_checker.sv | 133 +++++++++++++
 1 files changed

// File: rtl/and_gate_stim_checker.sv
`default_nettype none
// ============================================================================
// Module      : and_gate_stim_checker
// Description : Drives an exhaustive {a,b} sweep into a 2-input AND gate,
//               checks y against a&b and reports error/vector counts and pass.
// Revision    : 1.0 - initial release
// ============================================================================
module and_gate_stim_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [1:0]       first_err_vec
);

    localparam int C_SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int C_SWEEP_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [C_SETTLE_W-1:0] C_SETTLE_LAST = C_SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [C_SWEEP_W-1:0]  C_SWEEP_LAST  = C_SWEEP_W'(PASSES - 1);
    localparam logic [CNT_W-1:0]      C_CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    logic [1:0]            r_vec;
    logic [C_SWEEP_W-1:0]  r_sweep;
    logic [C_SETTLE_W-1:0] r_settle;

    logic                  w_mismatch;
    logic [CNT_W-1:0]      w_err_next;
    logic [CNT_W-1:0]      w_vec_next;

    // Case-inequality so an undriven or unknown y is reported as a failure.
    assign w_mismatch = (y !== (a & b));
    assign w_err_next = (w_mismatch && (err_count != C_CNT_MAX)) ? err_count + 1'b1 : err_count;
    assign w_vec_next = (vec_count != C_CNT_MAX) ? vec_count + 1'b1 : vec_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_vec         <= 2'd0;
            r_sweep       <= '0;
            r_settle      <= '0;
            a             <= 1'b0;
            b             <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            vec_count     <= '0;
            first_err_vec <= 2'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    a <= 1'b0;
                    b <= 1'b0;
                    if (start) begin
                        err_count     <= '0;
                        vec_count     <= '0;
                        first_err_vec <= 2'd0;
                        pass          <= 1'b0;
                        r_vec         <= 2'd0;
                        r_sweep       <= '0;
                        busy          <= 1'b1;
                        r_state       <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_settle <= '0;
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle == C_SETTLE_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_CHECK: begin
                    err_count <= w_err_next;
                    vec_count <= w_vec_next;
                    // err_count only grows within a run, so zero means no earlier miss.
                    if (w_mismatch && (err_count == '0)) begin
                        first_err_vec <= {a, b};
                    end
                    if (r_vec != 2'd3) begin
                        r_vec   <= r_vec + 2'd1;
                        {a, b}  <= r_vec + 2'd1;
                        r_state <= S_DRIVE;
                    end else if (r_sweep != C_SWEEP_LAST) begin
                        r_sweep <= r_sweep + 1'b1;
                        r_vec   <= 2'd0;
                        {a, b}  <= 2'd0;
                        r_state <= S_DRIVE;
                    end else begin
                        a       <= 1'b0;
                        b       <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == '0);
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
